// File: rtl/bm_input_hold_stage.sv
// bm_input_hold_stage
//   Per-master input stage of the AHB bus matrix. Forwards the master's
//   address phase to the output-stage arbiters. If the target output port
//   does not take it this cycle, the phase is parked in a holding register
//   and the master is stalled until the arbiter grants the port. The
//   downstream data-phase ready/response are returned to the master.
//
// Ports
//   HCLK, HRESETn          clock, async active-low reset
//   HSELS..HMASTLOCKS      master-side address phase
//   HREADYS                master-layer HREADY (address-phase sample point)
//   active_dec             target output port currently selects this port
//   readyout_dec, resp_dec target output port HREADY / HRESP
//   req_dec                transfer request to the output arbiters
//   HADDRM..HMASTLOCKM     address/control presented downstream
//   HREADYOUTS, HRESPS     ready/response returned to the master
module bm_input_hold_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSELS,
  input  logic [ADDR_WIDTH-1:0] HADDRS,
  input  logic [1:0]            HTRANSS,
  input  logic                  HWRITES,
  input  logic [2:0]            HSIZES,
  input  logic [2:0]            HBURSTS,
  input  logic [3:0]            HPROTS,
  input  logic                  HMASTLOCKS,
  input  logic                  HREADYS,
  input  logic                  active_dec,
  input  logic                  readyout_dec,
  input  logic                  resp_dec,
  output logic                  req_dec,
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic [1:0]            HTRANSM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [2:0]            HBURSTM,
  output logic [3:0]            HPROTM,
  output logic                  HMASTLOCKM,
  output logic                  HREADYOUTS,
  output logic                  HRESPS
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BU_INCR   = 3'b001;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            trans;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  lock;
  } ahb_ctrl_t;

  // {pend_reg, data_reg}; HELD and DATA are mutually exclusive
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HELD = 2'b10,
    ST_DATA = 2'b01
  } state_t;

  state_t    state;
  ahb_ctrl_t hold_reg;
  ahb_ctrl_t live;
  ahb_ctrl_t down;
  logic      pend_reg, data_reg;
  logic      live_valid, accept, capture;

  assign pend_reg   = state[1];
  assign data_reg   = state[0];
  assign live       = {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
  // only NONSEQ/SEQ are ever captured; BUSY/IDLE are dropped if not granted
  assign live_valid = HSELS & HTRANSS[1] & HREADYS;
  assign accept     = active_dec & readyout_dec;
  assign capture    = live_valid & ~accept;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      hold_reg <= '0;
    end else begin
      if (capture)
        hold_reg <= live;
      case (state)
        // master is stalled while HELD, so live inputs are not looked at
        ST_HELD: if (accept) state <= ST_DATA;
        default: begin
          if (capture)
            state <= ST_HELD;       // also covers DATA completing + new capture
          else if (accept & live_valid)
            state <= ST_DATA;
          else if (data_reg & ~readyout_dec)
            state <= ST_DATA;       // downstream wait state
          else
            state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    down = live;
    if (pend_reg) begin
      down = hold_reg;
      // arbitration may have split the burst: replay a held SEQ as a fresh INCR
      if (hold_reg.trans == TR_SEQ) begin
        down.trans = TR_NONSEQ;
        down.burst = BU_INCR;
      end
    end else if (!(HSELS && HREADYS)) begin
      down.trans = TR_IDLE;
    end
  end

  assign HADDRM     = down.addr;
  assign HTRANSM    = down.trans;
  assign HWRITEM    = down.write;
  assign HSIZEM     = down.size;
  assign HBURSTM    = down.burst;
  assign HPROTM     = down.prot;
  assign HMASTLOCKM = down.lock;

  assign req_dec    = pend_reg | live_valid;
  assign HREADYOUTS = pend_reg ? 1'b0 : (data_reg ? readyout_dec : 1'b1);
  assign HRESPS     = data_reg & resp_dec;

endmodule

// File: tb/tb_bm_input_hold_stage.sv
module tb_bm_input_hold_stage;
  localparam int AW = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSELS;
  logic [AW-1:0] HADDRS;
  logic [1:0]    HTRANSS;
  logic          HWRITES;
  logic [2:0]    HSIZES, HBURSTS;
  logic [3:0]    HPROTS;
  logic          HMASTLOCKS, HREADYS;
  logic          active_dec, readyout_dec, resp_dec;
  logic          req_dec;
  logic [AW-1:0] HADDRM;
  logic [1:0]    HTRANSM;
  logic          HWRITEM;
  logic [2:0]    HSIZEM, HBURSTM;
  logic [3:0]    HPROTM;
  logic          HMASTLOCKM, HREADYOUTS, HRESPS;

  // single-master layer: the master sees this stage's ready directly
  assign HREADYS = HREADYOUTS;

  bm_input_hold_stage #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS),
    .HTRANSS(HTRANSS), .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS),
    .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .active_dec(active_dec), .readyout_dec(readyout_dec), .resp_dec(resp_dec),
    .req_dec(req_dec), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
    .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  always #5 HCLK = ~HCLK;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    trans;
    logic          wr;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic [3:0]    prot;
    logic          lock;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge HCLK) cyc <= cyc + 1;

  // Scoreboard producer: every NONSEQ/SEQ the master issues must appear
  // downstream exactly once, in order. If it is not taken in the cycle it is
  // issued it is replayed later, and a replayed SEQ becomes NONSEQ/INCR.
  always @(negedge HCLK) begin
    exp_t e;
    if (HRESETn && HSELS && HTRANSS[1] && HREADYS) begin
      e.b   = {HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS};
      e.cyc = cyc;
      if (!(active_dec && readyout_dec) && HTRANSS == 2'b11) begin
        e.b.trans = 2'b10;
        e.b.burst = 3'b001;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: the master is stalled exactly while an issued transfer is still
  // waiting downstream; during a downstream data phase this port owns, the
  // slave's ready/response are returned to the master.
  logic own_dp = 1'b0;
  always @(negedge HCLK) begin
    logic  pending_old, live, exp_rdy;
    beat_t got;
    exp_t  e;
    #1;
    if (!HRESETn) begin
      own_dp = 1'b0;
    end else begin
      pending_old = (exp_q.size() > 0) && (exp_q[0].cyc != cyc);
      live        = HSELS & HTRANSS[1] & HREADYS;
      exp_rdy     = pending_old ? 1'b0 : (own_dp ? readyout_dec : 1'b1);
      chk("mon_hreadyouts", 64'(HREADYOUTS), 64'(exp_rdy));
      chk("mon_hresps", 64'(HRESPS), 64'(own_dp & resp_dec));
      chk("mon_req_dec", 64'(req_dec), 64'(pending_old | live));
      chk("mon_htransm_act", 64'(HTRANSM[1]), 64'(pending_old | live));
      if (pending_old) begin
        chk("mon_held_addr", 64'(HADDRM), 64'(exp_q[0].b.addr));
        chk("mon_held_trans", 64'(HTRANSM), 64'(2'b10));
      end
      if (active_dec && readyout_dec && HTRANSM[1]) begin
        got = {HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_spurious_beat actual=%0h required=none (t=%0t)", got, $time);
        end else begin
          e = exp_q.pop_front();
          chk("mon_beat", 64'(got), 64'(e.b));
        end
        own_dp = 1'b1;
      end else begin
        own_dp = own_dp & ~readyout_dec;
      end
    end
  end

  task automatic m_set(input logic sel, input logic [AW-1:0] a, input logic [1:0] tr,
                       input logic wr, input logic [2:0] burst, input logic lock);
    HSELS = sel; HADDRS = a; HTRANSS = tr; HWRITES = wr;
    HSIZES = 3'd2; HBURSTS = burst; HPROTS = 4'h3; HMASTLOCKS = lock;
  endtask

  task automatic m_idle();
    m_set(1'b0, '0, 2'b00, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic s_set(input logic act, input logic rdy, input logic rsp);
    active_dec = act; readyout_dec = rdy; resp_dec = rsp;
  endtask

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    logic r;
    HRESETn = 1'b0;
    m_idle();
    s_set(1'b0, 1'b1, 1'b0);
    #2;
    chk("rst_hreadyouts", 64'(HREADYOUTS), 64'd1);
    chk("rst_hresps", 64'(HRESPS), 64'd0);
    chk("rst_req_dec", 64'(req_dec), 64'd0);
    chk("rst_htransm", 64'(HTRANSM), 64'd0);
    next();
    HRESETn = 1'b1;

    // granted single write
    next();
    m_set(1'b1, 32'h2000_0010, 2'b10, 1'b1, 3'b000, 1'b0);
    s_set(1'b1, 1'b1, 1'b0);
    #3;
    chk("grant_htransm", 64'(HTRANSM), 64'(2'b10));
    chk("grant_haddrm", 64'(HADDRM), 64'h2000_0010);
    next();
    m_idle();
    #3 chk("grant_ready_next", 64'(HREADYOUTS), 64'd1);

    // blocked NONSEQ, master inputs turn to garbage while stalled
    next();
    m_set(1'b1, 32'h4000_0004, 2'b10, 1'b0, 3'b000, 1'b0);
    s_set(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      next();
      m_set(1'b1, $urandom, 2'($urandom), 1'($urandom), 3'($urandom), 1'($urandom));
      if (i == 2) active_dec = 1'b1;
      #3;
      chk("blk_stall", 64'(HREADYOUTS), 64'd0);
      chk("blk_haddrm", 64'(HADDRM), 64'h4000_0004);
    end
    chk("blk_issue", 64'(HTRANSM), 64'(2'b10));
    next();
    m_idle();
    #3 chk("blk_ready_after", 64'(HREADYOUTS), 64'(readyout_dec));

    // INCR4: beat 1 granted, beat 2 (SEQ) blocked while beat 1 completes
    next();
    m_set(1'b1, 32'h0000_0100, 2'b10, 1'b0, 3'b011, 1'b1);
    s_set(1'b1, 1'b1, 1'b0);
    next();
    m_set(1'b1, 32'h0000_0104, 2'b11, 1'b0, 3'b011, 1'b1);
    s_set(1'b0, 1'b1, 1'b0);
    #3 chk("b2b_req_live", 64'(req_dec), 64'd1);
    next();
    #3;
    chk("seq_req_held", 64'(req_dec), 64'd1);
    chk("seq_hbursts", 64'(HBURSTM), 64'(3'b001));
    chk("seq_htransm", 64'(HTRANSM), 64'(2'b10));
    chk("seq_haddrm", 64'(HADDRM), 64'h104);
    chk("seq_lock", 64'(HMASTLOCKM), 64'd1);
    active_dec = 1'b1;
    next();
    m_idle();

    // wait states then a two-cycle ERROR
    next();
    m_set(1'b1, 32'h3000_0000, 2'b10, 1'b1, 3'b000, 1'b0);
    s_set(1'b1, 1'b1, 1'b0);
    next(); m_idle(); readyout_dec = 1'b0; #3 chk("ws_0", 64'(HREADYOUTS), 64'd0);
    next(); #3 chk("ws_1", 64'(HREADYOUTS), 64'd0);
    next(); readyout_dec = 1'b1; #3 chk("ws_2", 64'(HREADYOUTS), 64'd1);
    next();
    m_set(1'b1, 32'h3000_0008, 2'b10, 1'b0, 3'b000, 1'b0);
    next(); m_idle(); s_set(1'b1, 1'b0, 1'b1);
    #3 chk("err_resp0", 64'(HRESPS), 64'd1); chk("err_rdy0", 64'(HREADYOUTS), 64'd0);
    next(); s_set(1'b1, 1'b1, 1'b1);
    #3 chk("err_resp1", 64'(HRESPS), 64'd1); chk("err_rdy1", 64'(HREADYOUTS), 64'd1);
    next(); resp_dec = 1'b0;

    // randomized traffic, master holds its phase until it is sampled
    for (int i = 0; i < 3000; i++) begin
      @(negedge HCLK);
      r = HREADYS;
      next();
      if (r)
        m_set(1'($urandom_range(7) != 0), $urandom, 2'($urandom), 1'($urandom),
              3'($urandom), 1'($urandom));
      s_set(1'($urandom_range(3) != 0), 1'($urandom_range(2) != 0),
            1'($urandom_range(7) == 0));
    end

    // drain
    next();
    m_idle();
    s_set(1'b1, 1'b1, 1'b0);
    repeat (6) next();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // reset while HELD: the held transfer must never be replayed
    m_set(1'b1, 32'h5000_0000, 2'b10, 1'b1, 3'b000, 1'b0);
    s_set(1'b0, 1'b1, 1'b0);
    next();
    #2 chk("rh_held", 64'(HREADYOUTS), 64'd0);
    HRESETn = 1'b0;
    m_idle();
    exp_q.delete();
    #1;
    chk("rh_hreadyouts", 64'(HREADYOUTS), 64'd1);
    chk("rh_req_dec", 64'(req_dec), 64'd0);
    chk("rh_htransm", 64'(HTRANSM), 64'd0);
    next();
    HRESETn = 1'b1;
    active_dec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3 chk("rh_no_replay", 64'(HTRANSM), 64'd0);
      next();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
